// File: rtl/des_sbox_sequencer.sv
// des_sbox_sequencer: drives one shared DES S-box port through S1..S8 for a
// 48-bit post-key-mix word and assembles the 32-bit substituted result.
// Optional macro DES_SBOX_PERMUTE_EN applies the DES P-permutation to out_data.
module des_sbox_sequencer #(
   parameter int unsigned SBOX_LAT = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [47:0] in_data,
   output logic [2:0]  sbox_sel,
   output logic [5:0]  sbox_in,
   input  logic [3:0]  sbox_out,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic        busy
);

   localparam int unsigned WW = (SBOX_LAT > 0) ? $clog2(SBOX_LAT + 1) : 1;
   localparam logic [WW-1:0] WMAX = WW'(SBOX_LAT);

   typedef enum logic [1:0] {StIdle, StLookup, StDone} state_e;

   state_e         state_q;
   logic [47:0]    shreg_q;
   logic [31:0]    result_q;
   logic [2:0]     k_q;
   logic [WW-1:0]  w_q;
   logic           in_ready_q;
   logic           out_valid_q;
   logic           busy_q;

   // Sequencer FSM; the chunk register shifts left so the active chunk is always
   // in the top six bits and drains to zero, keeping sbox_in at 0 outside LOOKUP.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         shreg_q     <= '0;
         result_q    <= '0;
         k_q         <= '0;
         w_q         <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (in_valid) begin
                  shreg_q    <= in_data;
                  result_q   <= '0;
                  k_q        <= '0;
                  w_q        <= '0;
                  state_q    <= StLookup;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
               end
            end
            StLookup: begin
               if (w_q == WMAX) begin
                  // Nibbles enter at the bottom so S1 ends up in [31:28].
                  result_q <= {result_q[27:0], sbox_out};
                  shreg_q  <= {shreg_q[41:0], 6'd0};
                  w_q      <= '0;
                  if (k_q == 3'd7) begin
                     k_q         <= '0;
                     state_q     <= StDone;
                     out_valid_q <= 1'b1;
                  end else begin
                     k_q <= k_q + 3'd1;
                  end
               end else begin
                  w_q <= w_q + 1'b1;
               end
            end
            StDone: begin
               if (out_ready) begin
                  state_q     <= StIdle;
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign sbox_sel  = k_q;
   assign sbox_in   = shreg_q[47:42];

`ifdef DES_SBOX_PERMUTE_EN
   // DES P-permutation: output bit i (1 = MSB) takes input bit P[i].
   assign out_data = {result_q[16], result_q[25], result_q[12], result_q[11],
                      result_q[3],  result_q[20], result_q[4],  result_q[15],
                      result_q[31], result_q[17], result_q[9],  result_q[6],
                      result_q[27], result_q[14], result_q[1],  result_q[22],
                      result_q[30], result_q[24], result_q[8],  result_q[18],
                      result_q[0],  result_q[5],  result_q[29], result_q[23],
                      result_q[13], result_q[19], result_q[2],  result_q[26],
                      result_q[10], result_q[21], result_q[28], result_q[7]};
`else
   assign out_data = result_q;
`endif

endmodule
